// File: rtl/locked_adder_key_sweep_engine_if.sv
// Bundle of the sweep engine's control, vector-memory, locked-DUT and readout
// signals. Names keep the engine's point of view (_i = into the engine).
//
// Handshake (vector memory): the engine raises vec_req_o with a stable
// vec_addr_o and holds both until a rising edge where vec_req_o and
// vec_valid_i are both high; vec_a_i/vec_b_i are transferred on that edge and
// vec_req_o drops the following cycle. vec_valid_i is ignored while
// vec_req_o is low.
//
// Modports: slave = the engine, master = whoever drives it (memory, DUT, host).
interface locked_adder_key_sweep_engine_if #(
   parameter int WIDTH    = 16,
   parameter int KEY_W    = 32,
   parameter int NUM_KEYS = 17,
   parameter int NUM_VEC  = 10000,
   parameter int CNT_W    = 16,
   parameter int HD_W     = 24
);
   localparam int KA_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int VA_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

   logic             start_i;
   logic             key_wr_en_i;
   logic [KA_W-1:0]  key_wr_addr_i;
   logic [KEY_W-1:0] key_wr_data_i;
   logic             vec_req_o;
   logic [VA_W-1:0]  vec_addr_o;
   logic             vec_valid_i;
   logic [WIDTH-1:0] vec_a_i;
   logic [WIDTH-1:0] vec_b_i;
   logic [WIDTH-1:0] dut_a_o;
   logic [WIDTH-1:0] dut_b_o;
   logic [KEY_W-1:0] dut_key_o;
   logic [WIDTH:0]   dut_result_i;
   logic [KA_W-1:0]  res_rd_addr_i;
   logic [CNT_W-1:0] res_mismatch_o;
   logic [HD_W-1:0]  res_hd_o;
   logic [CNT_W-1:0] approx_err_o;
   logic             busy_o;
   logic             done_o;
   logic [2:0]       state_dbg_o;   // FSM state, for debug/checkers

   modport slave (
      input  start_i, key_wr_en_i, key_wr_addr_i, key_wr_data_i,
      input  vec_valid_i, vec_a_i, vec_b_i, dut_result_i, res_rd_addr_i,
      output vec_req_o, vec_addr_o, dut_a_o, dut_b_o, dut_key_o,
      output res_mismatch_o, res_hd_o, approx_err_o, busy_o, done_o, state_dbg_o
   );

   modport master (
      output start_i, key_wr_en_i, key_wr_addr_i, key_wr_data_i,
      output vec_valid_i, vec_a_i, vec_b_i, dut_result_i, res_rd_addr_i,
      input  vec_req_o, vec_addr_o, dut_a_o, dut_b_o, dut_key_o,
      input  res_mismatch_o, res_hd_o, approx_err_o, busy_o, done_o, state_dbg_o
   );
endinterface

// File: rtl/locked_adder_key_sweep_engine.sv
// Key-sweep engine for a key-locked adder. Fetches operand pairs from a
// vector memory, applies each key of a programmable table to the locked DUT,
// and scores every key against slot 0 (the correct key): per-slot mismatch
// count and Hamming-distance sum. Slot 0 is also compared with the exact
// sum to count approximation errors.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset (aborts any sweep)
//   bus    - slave side of locked_adder_key_sweep_engine_if: start/key
//            write, vector request/response, DUT drive/result, result
//            readout, busy/done status and debug state.
module locked_adder_key_sweep_engine #(
   parameter int WIDTH    = 16,
   parameter int KEY_W    = 32,
   parameter int NUM_KEYS = 17,
   parameter int NUM_VEC  = 10000,
   parameter int DUT_LAT  = 0,
   parameter int CNT_W    = 16,
   parameter int HD_W     = 24
) (
   input logic clk_i,
   input logic rst_i,
   locked_adder_key_sweep_engine_if.slave bus
);
   localparam int KA_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int VA_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int LAT_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

   localparam logic [KA_W-1:0]  LAST_SLOT = KA_W'(NUM_KEYS - 1);
   localparam logic [VA_W-1:0]  LAST_VEC  = VA_W'(NUM_VEC - 1);
   localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_SETTLE  = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           state_q;
   logic [KEY_W-1:0] key_q  [NUM_KEYS];
   logic [CNT_W-1:0] mism_q [NUM_KEYS];
   logic [HD_W-1:0]  hd_q   [NUM_KEYS];
   logic [CNT_W-1:0] approx_q;
   logic [WIDTH:0]   ref_q;
   logic [KA_W-1:0]  slot_q;
   logic [LAT_W-1:0] settle_q;
   logic [VA_W-1:0]  vec_addr_q;
   logic             vec_req_q;
   logic [WIDTH-1:0] dut_a_q;
   logic [WIDTH-1:0] dut_b_q;
   logic [KEY_W-1:0] dut_key_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH:0]   exact_sum;
   logic [WIDTH:0]   diff;
   logic [HD_W:0]    hd_sum_d;     // one extra bit to detect overflow for saturation
   logic [KA_W-1:0]  slot_nx;
   logic [CNT_W-1:0] rd_mism;
   logic [HD_W-1:0]  rd_hd;

   function automatic logic [HD_W-1:0] popcnt(input logic [WIDTH:0] v);
      logic [HD_W-1:0] c;
      c = '0;
      for (int i = 0; i <= WIDTH; i++) c = c + HD_W'(v[i]);
      return c;
   endfunction

   always_comb begin
      exact_sum = {1'b0, dut_a_q} + {1'b0, dut_b_q};
      diff      = bus.dut_result_i ^ ref_q;
      hd_sum_d  = {1'b0, hd_q[slot_q]} + {1'b0, popcnt(diff)};
      slot_nx   = slot_q + 1'b1;
   end

   // Out-of-range readout addresses return zero rather than indexing past the table.
   always_comb begin
      rd_mism = '0;
      rd_hd   = '0;
      if (int'(bus.res_rd_addr_i) < NUM_KEYS) begin
         rd_mism = mism_q[bus.res_rd_addr_i];
         rd_hd   = hd_q[bus.res_rd_addr_i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         approx_q   <= '0;
         ref_q      <= '0;
         slot_q     <= '0;
         settle_q   <= '0;
         vec_addr_q <= '0;
         vec_req_q  <= 1'b0;
         dut_a_q    <= '0;
         dut_b_q    <= '0;
         dut_key_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_q[i]  <= '0;
            mism_q[i] <= '0;
            hd_q[i]   <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.key_wr_en_i && (int'(bus.key_wr_addr_i) < NUM_KEYS))
                  key_q[bus.key_wr_addr_i] <= bus.key_wr_data_i;
               if (bus.start_i) begin
                  for (int i = 0; i < NUM_KEYS; i++) begin
                     mism_q[i] <= '0;
                     hd_q[i]   <= '0;
                  end
                  approx_q   <= '0;
                  done_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  vec_addr_q <= '0;
                  vec_req_q  <= 1'b1;  // address 0 is valid together with the start
                  state_q    <= S_FETCH;
               end
            end

            S_FETCH: begin
               // After a vector the address has just advanced; the request
               // follows one cycle later so the memory sees a settled address.
               if (vec_req_q && bus.vec_valid_i) begin
                  dut_a_q   <= bus.vec_a_i;
                  dut_b_q   <= bus.vec_b_i;
                  dut_key_q <= key_q[0];
                  slot_q    <= '0;
                  settle_q  <= '0;
                  vec_req_q <= 1'b0;
                  state_q   <= (DUT_LAT == 0) ? S_CAPTURE : S_SETTLE;
               end else begin
                  vec_req_q <= 1'b1;
               end
            end

            S_SETTLE: begin
               if (settle_q == LAST_LAT) state_q <= S_CAPTURE;
               else settle_q <= settle_q + 1'b1;
            end

            S_CAPTURE: begin
               if (slot_q == '0) begin
                  ref_q <= bus.dut_result_i;
                  if ((bus.dut_result_i != exact_sum) && (approx_q != '1))
                     approx_q <= approx_q + 1'b1;
               end else if (bus.dut_result_i != ref_q) begin
                  if (mism_q[slot_q] != '1) mism_q[slot_q] <= mism_q[slot_q] + 1'b1;
                  hd_q[slot_q] <= hd_sum_d[HD_W] ? '1 : hd_sum_d[HD_W-1:0];
               end

               if (slot_q != LAST_SLOT) begin
                  slot_q    <= slot_nx;
                  dut_key_q <= key_q[slot_nx];
                  settle_q  <= '0;
                  state_q   <= (DUT_LAT == 0) ? S_CAPTURE : S_SETTLE;
               end else if (vec_addr_q != LAST_VEC) begin
                  vec_addr_q <= vec_addr_q + 1'b1;
                  state_q    <= S_FETCH;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.vec_req_o      = vec_req_q;
   assign bus.vec_addr_o     = vec_addr_q;
   assign bus.dut_a_o        = dut_a_q;
   assign bus.dut_b_o        = dut_b_q;
   assign bus.dut_key_o      = dut_key_q;
   assign bus.res_mismatch_o = rd_mism;
   assign bus.res_hd_o       = rd_hd;
   assign bus.approx_err_o   = approx_q;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;
   assign bus.state_dbg_o    = state_q;
endmodule

// File: tb/tb_locked_adder_key_sweep_engine.sv
module tb_locked_adder_key_sweep_engine;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        start_a, start_b, start_c;
   logic        key_wr_en;
   logic [1:0]  key_wr_addr;
   logic [31:0] key_wr_data;
   logic [1:0]  rd_addr;
   logic        force_b0;
   int          vec_delay;
   logic [15:0] mem_a [8];
   logic [15:0] mem_b [8];

   // A: 3 keys, 4 vectors, combinational DUT. B: 5 vectors, 2-bit counters. C: DUT_LAT=2.
   locked_adder_key_sweep_engine_if #(.WIDTH(16), .KEY_W(32), .NUM_KEYS(3), .NUM_VEC(4), .CNT_W(16), .HD_W(24)) ifa ();
   locked_adder_key_sweep_engine_if #(.WIDTH(16), .KEY_W(32), .NUM_KEYS(3), .NUM_VEC(5), .CNT_W(2),  .HD_W(24)) ifb ();
   locked_adder_key_sweep_engine_if #(.WIDTH(16), .KEY_W(32), .NUM_KEYS(3), .NUM_VEC(4), .CNT_W(16), .HD_W(24)) ifc ();

   locked_adder_key_sweep_engine #(.WIDTH(16), .KEY_W(32), .NUM_KEYS(3), .NUM_VEC(4), .DUT_LAT(0), .CNT_W(16), .HD_W(24))
      dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
   locked_adder_key_sweep_engine #(.WIDTH(16), .KEY_W(32), .NUM_KEYS(3), .NUM_VEC(5), .DUT_LAT(0), .CNT_W(2), .HD_W(24))
      dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
   locked_adder_key_sweep_engine #(.WIDTH(16), .KEY_W(32), .NUM_KEYS(3), .NUM_VEC(4), .DUT_LAT(2), .CNT_W(16), .HD_W(24))
      dut_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

   // ---------------- vector memory responders and locked-adder models ----------------
   int wc_a = 0, wc_b = 0, wc_c = 0;
   logic [31:0] kx_a, kx_b, kx_c;
   logic [16:0] r_a, r_b, r_c;

   assign ifa.start_i = start_a;   assign ifb.start_i = start_b;   assign ifc.start_i = start_c;
   assign ifa.key_wr_en_i = key_wr_en;     assign ifb.key_wr_en_i = key_wr_en;     assign ifc.key_wr_en_i = key_wr_en;
   assign ifa.key_wr_addr_i = key_wr_addr; assign ifb.key_wr_addr_i = key_wr_addr; assign ifc.key_wr_addr_i = key_wr_addr;
   assign ifa.key_wr_data_i = key_wr_data; assign ifb.key_wr_data_i = key_wr_data; assign ifc.key_wr_data_i = key_wr_data;
   assign ifa.res_rd_addr_i = rd_addr;     assign ifb.res_rd_addr_i = rd_addr;     assign ifc.res_rd_addr_i = rd_addr;

   always @(posedge clk) wc_a <= ifa.vec_req_o ? wc_a + 1 : 0;
   always @(posedge clk) wc_b <= ifb.vec_req_o ? wc_b + 1 : 0;
   always @(posedge clk) wc_c <= ifc.vec_req_o ? wc_c + 1 : 0;

   always_comb begin
      ifa.vec_valid_i = ifa.vec_req_o && (wc_a >= vec_delay);
      ifa.vec_a_i = mem_a[ifa.vec_addr_o];
      ifa.vec_b_i = mem_b[ifa.vec_addr_o];
      kx_a = ifa.dut_key_o ^ 32'h00B89EB1;
      r_a = ({1'b0, ifa.dut_a_o} + {1'b0, ifa.dut_b_o}) ^ kx_a[16:0];
      if (force_b0) r_a[0] = 1'b0;
      ifa.dut_result_i = r_a;
   end

   always_comb begin
      ifb.vec_valid_i = ifb.vec_req_o && (wc_b >= vec_delay);
      ifb.vec_a_i = mem_a[ifb.vec_addr_o];
      ifb.vec_b_i = mem_b[ifb.vec_addr_o];
      kx_b = ifb.dut_key_o ^ 32'h00B89EB1;
      r_b = ({1'b0, ifb.dut_a_o} + {1'b0, ifb.dut_b_o}) ^ kx_b[16:0];
      if (force_b0) r_b[0] = 1'b0;
      ifb.dut_result_i = r_b;
   end

   always_comb begin
      ifc.vec_valid_i = ifc.vec_req_o && (wc_c >= vec_delay);
      ifc.vec_a_i = mem_a[ifc.vec_addr_o];
      ifc.vec_b_i = mem_b[ifc.vec_addr_o];
      kx_c = ifc.dut_key_o ^ 32'h00B89EB1;
      r_c = ({1'b0, ifc.dut_a_o} + {1'b0, ifc.dut_b_o}) ^ kx_c[16:0];
      if (force_b0) r_c[0] = 1'b0;
      ifc.dut_result_i = r_c;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic done_of(input int inst);
      case (inst)
         0:       return ifa.done_o;
         1:       return ifb.done_o;
         default: return ifc.done_o;
      endcase
   endfunction

   function automatic logic busy_of(input int inst);
      case (inst)
         0:       return ifa.busy_o;
         1:       return ifb.busy_o;
         default: return ifc.busy_o;
      endcase
   endfunction

   function automatic logic [31:0] mism_of(input int inst);
      case (inst)
         0:       return 32'(ifa.res_mismatch_o);
         1:       return 32'(ifb.res_mismatch_o);
         default: return 32'(ifc.res_mismatch_o);
      endcase
   endfunction

   function automatic logic [31:0] hd_of(input int inst);
      case (inst)
         0:       return 32'(ifa.res_hd_o);
         1:       return 32'(ifb.res_hd_o);
         default: return 32'(ifc.res_hd_o);
      endcase
   endfunction

   function automatic logic [31:0] approx_of(input int inst);
      case (inst)
         0:       return 32'(ifa.approx_err_o);
         1:       return 32'(ifb.approx_err_o);
         default: return 32'(ifc.approx_err_o);
      endcase
   endfunction

   task automatic set_start(input int inst, input logic v);
      case (inst)
         0:       start_a = v;
         1:       start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic write_keys(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2);
      logic [31:0] k [3];
      k[0] = k0; k[1] = k1; k[2] = k2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         key_wr_en = 1'b1; key_wr_addr = 2'(i); key_wr_data = k[i];
      end
      @(negedge clk);
      key_wr_en = 1'b0;
   endtask

   // mode 0: plain; 1: poke start + key write while busy; 2: check hold during
   // the vector-1 wait; 3: stop when vec_addr reaches 2. cyc = cycles start->done.
   task automatic sweep(input int inst, input int mode, output int cyc);
      int held;
      held = 0;
      cyc  = 0;
      @(negedge clk); set_start(inst, 1'b1);
      @(negedge clk); set_start(inst, 1'b0);
      while (!done_of(inst) && cyc < 1000) begin
         if (mode == 1) begin
            if (cyc == 7) begin
               start_a = 1'b1; key_wr_en = 1'b1; key_wr_addr = 2'd2; key_wr_data = 32'h00B89E00;
            end else begin
               start_a = 1'b0; key_wr_en = 1'b0;
            end
         end
         if (mode == 2 && ifa.vec_addr_o == 2'd1 && ifa.vec_req_o) begin
            held++;
            chk("hold_a", ifa.dut_a_o, mem_a[0]);
            chk("hold_b", ifa.dut_b_o, mem_b[0]);
            chk("hold_key", ifa.dut_key_o, 32'h00B89EB0);
         end
         if (mode == 3 && ifa.vec_addr_o == 2'd2) break;
         @(negedge clk);
         cyc++;
      end
      start_a = 1'b0;
      key_wr_en = 1'b0;
      if (mode == 2) chk("req_held_cycles", held, vec_delay + 1);
      if (mode != 3) begin
         chk("sweep_done", done_of(inst), 1'b1);
         chk("sweep_busy", busy_of(inst), 1'b0);
      end
   endtask

   task automatic res_chk(input int inst, input string tag, input int m1, input int h1,
                          input int m2, input int h2, input int ap);
      int em [3];
      int eh [3];
      em[0] = 0; em[1] = m1; em[2] = m2;
      eh[0] = 0; eh[1] = h1; eh[2] = h2;
      for (int s = 0; s < 3; s++) begin
         rd_addr = 2'(s);
         #1;
         chk($sformatf("%s_mism%0d", tag, s), mism_of(inst), 32'(em[s]));
         chk($sformatf("%s_hd%0d", tag, s), hd_of(inst), 32'(eh[s]));
      end
      chk({tag, "_approx"}, approx_of(inst), 32'(ap));
   endtask

   task automatic load_scn1_vectors();
      mem_a[0] = 16'h0001; mem_b[0] = 16'h0002;
      mem_a[1] = 16'hFFFF; mem_b[1] = 16'h0001;
      mem_a[2] = 16'h1234; mem_b[2] = 16'h4321;
      mem_a[3] = 16'hFFFF; mem_b[3] = 16'hFFFF;
      mem_a[4] = 16'h8000; mem_b[4] = 16'h8000;
      mem_a[5] = 16'h0000; mem_b[5] = 16'h0000;
      mem_a[6] = 16'h0000; mem_b[6] = 16'h0000;
      mem_a[7] = 16'h0000; mem_b[7] = 16'h0000;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
      rd_addr = '0; force_b0 = 1'b0; vec_delay = 0;
      load_scn1_vectors();
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", ifa.busy_o, 1'b0);
      chk("rst_done", ifa.done_o, 1'b0);
      chk("rst_req", ifa.vec_req_o, 1'b0);
      chk("rst_addr", ifa.vec_addr_o, 2'd0);
      chk("rst_dut_a", ifa.dut_a_o, 16'h0);
      chk("rst_dut_key", ifa.dut_key_o, 32'h0);
      chk("rst_approx", ifa.approx_err_o, 16'h0);
      rst = 1'b0;

      // Scenario 1: keys {B1, B1, B0}, 4 vectors
      write_keys(32'h00B89EB1, 32'h00B89EB1, 32'h00B89EB0);
      sweep(0, 0, cyc);
      chk("s1_cycles", cyc, 19);
      res_chk(0, "s1", 0, 0, 4, 4, 0);
      repeat (3) @(negedge clk);
      chk("s1_done_hold", ifa.done_o, 1'b1);
      res_chk(0, "s1_hold", 0, 0, 4, 4, 0);

      // Same scenario on the DUT_LAT=2 engine: 4*(2+3*3)-1 cycles
      sweep(2, 0, cyc);
      chk("s1c_cycles", cyc, 43);
      res_chk(2, "s1c", 0, 0, 4, 4, 0);

      // Scenario 2: vec_valid delayed 5 cycles per request
      vec_delay = 5;
      sweep(0, 2, cyc);
      res_chk(0, "s2", 0, 0, 4, 4, 0);
      vec_delay = 0;

      // Scenario 3: reset while vec_addr == 2, then restart
      sweep(0, 3, cyc);
      chk("s3_reached_addr2", ifa.vec_addr_o, 2'd2);
      rd_addr = 2'd2;
      #1;
      chk("s3_mism2_before_rst", ifa.res_mismatch_o, 16'd2);
      chk("s3_hd2_before_rst", ifa.res_hd_o, 24'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("s3_busy", ifa.busy_o, 1'b0);
      chk("s3_done", ifa.done_o, 1'b0);
      chk("s3_addr", ifa.vec_addr_o, 2'd0);
      chk("s3_req", ifa.vec_req_o, 1'b0);
      chk("s3_key", ifa.dut_key_o, 32'h0);
      res_chk(0, "s3_rst", 0, 0, 0, 0, 0);
      write_keys(32'h00B89EB1, 32'h00B89EB1, 32'h00B89EB0);
      sweep(0, 0, cyc);
      chk("s3_restart_cycles", cyc, 19);
      res_chk(0, "s3_restart", 0, 0, 4, 4, 0);

      // Scenario 4: start and key write while busy are ignored
      sweep(0, 1, cyc);
      chk("s4_cycles", cyc, 19);
      res_chk(0, "s4", 0, 0, 4, 4, 0);

      // Scenario 5: CNT_W=2, 5 vectors, key[1] wrong in bit 0
      write_keys(32'h00B89EB1, 32'h00B89EB0, 32'h00B89EB1);
      sweep(1, 0, cyc);
      chk("s5_cycles", cyc, 24);
      res_chk(1, "s5", 3, 5, 0, 0, 0);

      // Scenario 6: model forces result bit 0 low; only (1,0) differs from a+b
      force_b0 = 1'b1;
      mem_a[0] = 16'd1; mem_b[0] = 16'd0;
      mem_a[1] = 16'd2; mem_b[1] = 16'd2;
      mem_a[2] = 16'd4; mem_b[2] = 16'd4;
      mem_a[3] = 16'd0; mem_b[3] = 16'd0;
      write_keys(32'h00B89EB1, 32'h00B89EB1, 32'h00B89EB0);
      sweep(0, 0, cyc);
      res_chk(0, "s6", 0, 0, 0, 0, 1);
      sweep(2, 0, cyc);
      chk("s6c_cycles", cyc, 43);
      res_chk(2, "s6c", 0, 0, 0, 0, 1);
      force_b0 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
